regbank_sequencer: RTL and testbench
====================================

Name: regbank_sequencer

Overview:
- Initiator side of the single-port RegisterBank interface (clk, regNum, dataIn, dataOut, writeEnable).
- Accepts a two-operand read request and a one-register write-back request from the CPU core.
- Serialises them onto the bank's single port: one access per cycle.
- Returns both operands together on a response handshake.
- Sits between the decode/execute logic and RegisterBank.

Parameters:
- DATA_WIDTH, 32, width of register data.
- REG_ADDR_WIDTH, 4, register index width (16 registers; index 0 reads as zero).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = in reset), sampled on rising clk.
- req_valid  input  1  read request valid.
- req_ready  output  1  read request accepted when req_valid && req_ready at clk edge.
- req_rs1  input  REG_ADDR_WIDTH  first operand index.
- req_rs2  input  REG_ADDR_WIDTH  second operand index.
- rsp_valid  output  1  operands valid; held until rsp_ready.
- rsp_ready  input  1  consumer accepts response.
- rsp_rs1_data  output  DATA_WIDTH  value of req_rs1.
- rsp_rs2_data  output  DATA_WIDTH  value of req_rs2.
- wr_valid  input  1  write-back request valid.
- wr_ready  output  1  write accepted when wr_valid && wr_ready.
- wr_rd  input  REG_ADDR_WIDTH  destination index.
- wr_data  input  DATA_WIDTH  write-back value.
- regNum  output  REG_ADDR_WIDTH  bank register select.
- dataIn  output  DATA_WIDTH  bank write data.
- writeEnable  output  1  bank write strobe (1 = write at this edge).
- dataOut  input  DATA_WIDTH  bank read data; reflects the regNum driven in the previous cycle (one-cycle read latency).

Behaviour:
- States:
  - IDLE
  - RD1: drive rs1.
  - RD2: drive rs2, capture rs1 data.
  - CAP2: capture rs2 data.
  - RESP
  - WR
- Reset (reset==0 at an edge):
  - state=IDLE.
  - regNum=0, dataIn=0, writeEnable=0.
  - rsp_valid=0, rsp_rs1_data=0, rsp_rs2_data=0.
  - All latched indices and data cleared.
- Reset mid-operation aborts the transaction: no response is produced, and no writeEnable appears in the cycle following reset.
- Ready outputs:
  - wr_ready = (state==IDLE).
  - req_ready = (state==IDLE) && !wr_valid. Writes have priority over reads; a simultaneous read request waits.
  - Both are combinational from state and wr_valid, and are 0 during reset.
- IDLE:
  - Write accepted: latch wr_rd/wr_data, go to WR.
  - Else read accepted: latch req_rs1/req_rs2, go to RD1.
  - Else stay in IDLE.
- WR (one cycle): regNum=latched rd, dataIn=latched data, writeEnable=1 iff rd!=0; then IDLE. A write to x0 completes the handshake with no bank write.
- RD1: regNum=rs1, writeEnable=0; go to RD2.
- RD2: regNum=rs2; on the edge, rsp_rs1_data <= (rs1==0) ? 0 : dataOut; go to CAP2.
- CAP2: on the edge, rsp_rs2_data <= (rs2==0) ? 0 : dataOut; rsp_valid <= 1; go to RESP.
- RESP:
  - rsp_valid=1 and data stable while rsp_ready=0.
  - On rsp_ready: rsp_valid <= 0, go to IDLE.
  - Data registers keep their last values after the handshake.
- Latency: a read accepted at edge N gives rsp_valid=1 after edge N+3. Minimum back-to-back read throughput is one request per 5 cycles (response accepted the same cycle it appears).
- writeEnable is 1 only in state WR; it is never asserted in any read state. dataIn is 0 outside WR.
- regNum holds its last driven value in IDLE and RESP (no extra bank side effects).
- rs1==rs2 is legal: the same register is read twice.
- A write accepted in IDLE completes in WR before any subsequent read's RD1. A read requested right after a write therefore sees the new value (read-after-write ordering guaranteed).
- Inputs on the request ports are ignored outside the accepting cycle.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wr_valid=1, req_valid=1 -> writeEnable=0, rsp_valid=0, regNum=0, req_ready=wr_ready=0 throughout.
- Write then read: write rd=5, data=32'hFFFFFFFF; then read rs1=5, rs2=3 (reg3=0) -> one cycle with regNum=5, writeEnable=1, dataIn=32'hFFFFFFFF; then rsp_rs1_data=32'hFFFFFFFF, rsp_rs2_data=0, rsp_valid exactly 3 edges after read acceptance.
- x0 handling: write rd=0, data=32'h12345678 -> writeEnable stays 0, wr handshake completes; preload bank reg0=32'hDEADBEEF and read rs1=0, rs2=0 -> both data outputs 0.
- Priority: wr_valid and req_valid both high in IDLE (write rd=7, data=32'hF0F0F0F0; read rs1=rs2=7) -> write accepted first, req_ready=0 that cycle; read then returns 32'hF0F0F0F0 on both operands.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP; toggle req_valid and wr_valid -> rsp_valid and data stable, req_ready=wr_ready=0, no bank access; rsp_ready=1 -> IDLE next cycle.
- Sweep: for i=1..15 write 32'hFFFFFFFF to reg i, then read rs1=i, rs2=(i%15)+1 -> rs1 data 32'hFFFFFFFF; rs2 data 32'hFFFFFFFF only if already written, else 0; no other bank register modified.

Source files
------------

// File: rtl/regbank_sequencer.sv
// Initiator for a single-port register bank: serialises a two-operand read and a
// one-register write-back onto the bank port, one access per cycle.
module regbank_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [REG_ADDR_WIDTH-1:0] req_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] req_rs2,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rs1_data,
  output logic [DATA_WIDTH-1:0]     rsp_rs2_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [REG_ADDR_WIDTH-1:0] wr_rd,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic [REG_ADDR_WIDTH-1:0] regNum,
  output logic [DATA_WIDTH-1:0]     dataIn,
  output logic                      writeEnable,
  input  logic [DATA_WIDTH-1:0]     dataOut
);

  typedef enum logic [2:0] {
    StIdle,
    StRd1,
    StRd2,
    StCap2,
    StResp,
    StWr
  } state_e;

  state_e                    state_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_q;

  // Writes win over reads in IDLE so a read issued alongside a write sees its result.
  assign wr_ready  = reset && (state_q == StIdle);
  assign req_ready = reset && (state_q == StIdle) && !wr_valid;

  // Bank port signals are registered on the transition into the state that owns them,
  // so regNum/dataIn/writeEnable are valid for the whole cycle of that state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      rs1_q        <= '0;
      rs2_q        <= '0;
      regNum       <= '0;
      dataIn       <= '0;
      writeEnable  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rs1_data <= '0;
      rsp_rs2_data <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wr_valid) begin
            regNum      <= wr_rd;
            dataIn      <= wr_data;
            writeEnable <= (wr_rd != '0);
            state_q     <= StWr;
          end else if (req_valid) begin
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
            regNum  <= req_rs1;
            state_q <= StRd1;
          end
        end
        StWr: begin
          writeEnable <= 1'b0;
          dataIn      <= '0;
          state_q     <= StIdle;
        end
        StRd1: begin
          regNum  <= rs2_q;
          state_q <= StRd2;
        end
        StRd2: begin
          // dataOut now reflects rs1, driven during RD1.
          rsp_rs1_data <= (rs1_q == '0) ? '0 : dataOut;
          state_q      <= StCap2;
        end
        StCap2: begin
          rsp_rs2_data <= (rs2_q == '0) ? '0 : dataOut;
          rsp_valid    <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_sequencer.sv
// Bench for regbank_sequencer: behavioural bank, architectural-state model with a per-cycle
// compare, and directed transactions with hand-computed expectations.
module tb_regbank_sequencer;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [AW-1:0] req_rs1 = '0, req_rs2 = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rs1_data, rsp_rs2_data;
  logic          wr_valid = 1'b0, wr_ready;
  logic [AW-1:0] wr_rd = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] regNum;
  logic [DW-1:0] dataIn;
  logic          writeEnable;
  logic [DW-1:0] dataOut;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regbank_sequencer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_rd(wr_rd), .wr_data(wr_data),
    .regNum(regNum), .dataIn(dataIn), .writeEnable(writeEnable), .dataOut(dataOut)
  );

  // Behavioural register bank with one-cycle read latency and a backdoor preload port.
  logic [DW-1:0] mem [16];
  logic          mem_init = 1'b0;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem_init <= 1'b1;
    end else if (pre_en) mem[pre_addr] <= pre_data;
    else if (writeEnable) mem[regNum] <= dataIn;
    dataOut <= mem[regNum];
  end

  // Architectural model: register contents plus transaction timing.
  logic [DW-1:0] arch [16];
  logic          started = 1'b0;
  logic          m_last_rst = 1'b0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_rd = '0;
  logic [DW-1:0] m_wd = '0;
  int            m_cnt = 0;
  logic          m_rsp = 1'b0;
  logic [DW-1:0] m_p1 = '0, m_p2 = '0, m_e1 = '0, m_e2 = '0;
  logic          m_idle;

  assign m_idle = !m_wr && (m_cnt == 0) && !m_rsp;

  always @(posedge clk) begin
    started    <= 1'b1;
    m_last_rst <= !reset;
    if (!mem_init) for (int i = 0; i < 16; i++) arch[i] <= '0;
    else if (pre_en) arch[pre_addr] <= pre_data;
    if (!reset) begin
      m_wr  <= 1'b0;
      m_cnt <= 0;
      m_rsp <= 1'b0;
      m_e1  <= '0;
      m_e2  <= '0;
    end else begin
      m_wr <= 1'b0;
      if (m_idle && wr_valid) begin
        m_wr <= 1'b1;
        m_rd <= wr_rd;
        m_wd <= wr_data;
        if (wr_rd != 0) arch[wr_rd] <= wr_data;
      end else if (m_idle && req_valid) begin
        m_cnt <= 3;
        m_p1  <= (req_rs1 == 0) ? '0 : arch[req_rs1];
        m_p2  <= (req_rs2 == 0) ? '0 : arch[req_rs2];
      end
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_rsp <= 1'b1;
          m_e1  <= m_p1;
          m_e2  <= m_p2;
        end
      end
      if (m_rsp && rsp_ready) m_rsp <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, well clear of both the driving negedge and the active edge.
  always @(negedge clk) begin
    #2;
    if (started) begin
      check("req_ready", DW'(req_ready), DW'(reset && m_idle && !wr_valid));
      check("wr_ready", DW'(wr_ready), DW'(reset && m_idle));
      check("rsp_valid", DW'(rsp_valid), DW'(m_rsp));
      check("writeEnable", DW'(writeEnable), DW'(m_wr && (m_rd != 0)));
      if (m_wr) begin
        check("wr_regNum", DW'(regNum), DW'(m_rd));
        check("wr_dataIn", dataIn, m_wd);
      end else check("idle_dataIn", dataIn, '0);
      if (m_rsp) begin
        check("rsp_rs1_data", rsp_rs1_data, m_e1);
        check("rsp_rs2_data", rsp_rs2_data, m_e2);
      end
      if (m_last_rst) check("reset_regNum", DW'(regNum), '0);
    end
  end

  task automatic do_write(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    int k;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_rd    = rd;
    wr_data  = data;
    #1;
    k = 0;
    while (!wr_ready && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 20) check("wr_accept_timeout", 0, 1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         output int lat, output logic [DW-1:0] d1, output logic [DW-1:0] d2);
    int k;
    @(negedge clk);
    req_valid = 1'b1;
    req_rs1   = rs1;
    req_rs2   = rs2;
    #1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 20) check("rd_accept_timeout", 0, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) check("rsp_timeout", 0, 1);
    d1 = rsp_rs1_data;
    d2 = rsp_rs2_data;
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int            lat;
    logic [DW-1:0] d1, d2;
    logic [AW-1:0] held_num;

    // Reset with both request valids asserted.
    wr_valid  = 1'b1;
    req_valid = 1'b1;
    wr_rd     = 4'd3;
    wr_data   = 32'h0000_0042;
    #1;
    check("rst_wr_ready", DW'(wr_ready), 0);
    check("rst_req_ready", DW'(req_ready), 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_we", DW'(writeEnable), 0);
      check("rst_rsp_valid", DW'(rsp_valid), 0);
      check("rst_regNum", DW'(regNum), 0);
    end
    wr_valid  = 1'b0;
    req_valid = 1'b0;
    reset     = 1'b1;

    // Write to x0 never strobes the bank; x0 reads return zero regardless of bank contents.
    do_write(4'd0, 32'h1234_5678);
    #1;
    check("x0_we", DW'(writeEnable), 0);
    @(negedge clk);
    check("x0_mem_untouched", mem[0], 32'h0);
    preload(4'd0, 32'hDEAD_BEEF);
    do_read(4'd0, 4'd0, lat, d1, d2);
    check("x0_lat", DW'(lat), 3);
    check("x0_rs1", d1, 32'h0);
    check("x0_rs2", d2, 32'h0);
    accept_rsp();

    // Write then read.
    do_write(4'd5, 32'hFFFF_FFFF);
    #1;
    check("w5_regNum", DW'(regNum), 5);
    check("w5_we", DW'(writeEnable), 1);
    check("w5_dataIn", dataIn, 32'hFFFF_FFFF);
    do_read(4'd5, 4'd3, lat, d1, d2);
    check("r53_lat", DW'(lat), 3);
    check("r53_rs1", d1, 32'hFFFF_FFFF);
    check("r53_rs2", d2, 32'h0);
    accept_rsp();

    // Simultaneous write and read: write goes first.
    @(negedge clk);
    wr_valid  = 1'b1;
    wr_rd     = 4'd7;
    wr_data   = 32'hF0F0_F0F0;
    req_valid = 1'b1;
    req_rs1   = 4'd7;
    req_rs2   = 4'd7;
    #1;
    check("prio_req_ready", DW'(req_ready), 0);
    check("prio_wr_ready", DW'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0;
    do_read(4'd7, 4'd7, lat, d1, d2);
    check("prio_rs1", d1, 32'hF0F0_F0F0);
    check("prio_rs2", d2, 32'hF0F0_F0F0);
    accept_rsp();

    // Backpressure in RESP with toggling request valids.
    do_read(4'd5, 4'd7, lat, d1, d2);
    held_num = regNum;
    for (int k = 0; k < 10; k++) begin
      wr_valid  = k[0];
      req_valid = !k[0];
      wr_rd     = 4'd9;
      wr_data   = 32'(k) + 32'h100;
      req_rs1   = 4'd9;
      req_rs2   = 4'd9;
      #1;
      check("bp_rsp_valid", DW'(rsp_valid), 1);
      check("bp_rs1", rsp_rs1_data, 32'hFFFF_FFFF);
      check("bp_rs2", rsp_rs2_data, 32'hF0F0_F0F0);
      check("bp_ready", DW'({req_ready, wr_ready}), 0);
      check("bp_regNum", DW'(regNum), DW'(held_num));
      @(negedge clk);
    end
    wr_valid  = 1'b0;
    req_valid = 1'b0;
    accept_rsp();
    #1;
    check("bp_back_idle", DW'(wr_ready), 1);
    check("bp_rsp_dropped", DW'(rsp_valid), 0);
    check("bp_no_write9", mem[9], 32'h0);

    // Sweep over a cleared bank.
    for (int i = 1; i < 16; i++) preload(AW'(i), 32'h0);
    for (int i = 1; i < 16; i++) begin
      do_write(AW'(i), 32'hFFFF_FFFF);
      do_read(AW'(i), AW'((i % 15) + 1), lat, d1, d2);
      check("sweep_lat", DW'(lat), 3);
      check("sweep_rs1", d1, 32'hFFFF_FFFF);
      check("sweep_rs2", d2, (i == 15) ? 32'hFFFF_FFFF : 32'h0);
      accept_rsp();
    end
    @(negedge clk);
    check("sweep_mem0", mem[0], 32'hDEAD_BEEF);
    for (int i = 1; i < 16; i++) check("sweep_mem", mem[i], 32'hFFFF_FFFF);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
